// File: rtl/msg_schedule.sv
// SHA-1 message schedule generator: expands one 512-bit block into W[0..79]
// using a 16-word circular buffer, streamed with valid/ready handshaking.
module msg_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    input  logic [511:0] blk_data,
    output logic         blk_ready,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [7:0]   w_cnt,
    input  logic         sched_abort,
    output logic         sched_done
);
    localparam logic [7:0] LAST_CNT = 8'd79;
    localparam logic [7:0] EXP_CNT  = 8'd16;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        done_q;
    logic [31:0] buf_q [16];

    logic [3:0]  idx;
    logic [3:0]  idx_m3;
    logic [3:0]  idx_m8;
    logic [3:0]  idx_m14;
    logic [31:0] w_exp;
    logic [31:0] w_cur;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    // Offsets +13/+8/+2 modulo 16 address W[t-3], W[t-8], W[t-14] in the ring.
    assign idx     = cnt_q[3:0];
    assign idx_m3  = idx + 4'd13;
    assign idx_m8  = idx + 4'd8;
    assign idx_m14 = idx + 4'd2;
    assign w_exp   = rotl1(buf_q[idx_m3] ^ buf_q[idx_m8] ^ buf_q[idx_m14] ^ buf_q[idx]);
    assign w_cur   = (cnt_q < EXP_CNT) ? buf_q[idx] : w_exp;

    assign blk_ready  = (state_q == IDLE);
    assign w_valid    = (state_q == STREAM);
    assign w_data     = w_cur;
    assign w_cnt      = cnt_q;
    assign sched_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (blk_valid && !sched_abort) begin
                        for (int i = 0; i < 16; i++) begin
                            buf_q[i] <= blk_data[511 - 32*i -: 32];
                        end
                        cnt_q   <= '0;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    // Abort wins over a coincident transfer: W[t] is not consumed.
                    if (sched_abort) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (w_ready) begin
                        if (cnt_q >= EXP_CNT) begin
                            buf_q[idx] <= w_exp;
                        end
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: SHA-1 schedule vectors, backpressure,
// back-to-back blocks, abort and asynchronous reset.
module tb_msg_schedule;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         blk_valid = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_ready;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_data;
    logic [7:0]   w_cnt;
    logic         sched_abort = 1'b0;
    logic         sched_done;

    int checks = 0;
    int failures = 0;

    localparam logic [511:0] BLK_ABC  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_ONES = {16{32'hFFFFFFFF}};
    localparam logic [127:0] HAND_ABC  = {32'hC2C4C700, 32'h00000000, 32'h00000030, 32'h85898E01};
    localparam logic [127:0] HAND_ONES = {32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};

    msg_schedule dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .blk_valid   (blk_valid),
        .blk_data    (blk_data),
        .blk_ready   (blk_ready),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .w_cnt       (w_cnt),
        .sched_abort (sched_abort),
        .sched_done  (sched_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sha1_w(input logic [511:0] blk, input int t);
        logic [31:0] w [0:79];
        logic [31:0] x;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {x[30:0], x[31]};
        end
        return w[t];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams all 80 words with w_ready high, checking each against the model.
    task automatic run_stream(input logic [511:0] blk, input logic [127:0] hand, input string pfx);
        w_ready = 1'b1;
        for (int t = 0; t < 80; t++) begin
            chk($sformatf("%s_valid%0d", pfx, t), {31'd0, w_valid}, 32'd1);
            chk($sformatf("%s_cnt%0d", pfx, t), {24'd0, w_cnt}, t);
            chk($sformatf("%s_w%0d", pfx, t), w_data, sha1_w(blk, t));
            chk($sformatf("%s_done%0d", pfx, t), {31'd0, sched_done}, 32'd0);
            chk($sformatf("%s_rdy%0d", pfx, t), {31'd0, blk_ready}, 32'd0);
            if (t < 16) chk($sformatf("%s_ld%0d", pfx, t), w_data, blk[511 - 32*t -: 32]);
            if (t >= 16 && t <= 19) chk($sformatf("%s_hand%0d", pfx, t), w_data, hand[127 - 32*(t-16) -: 32]);
            step();
        end
        chk({pfx, "_done_pulse"}, {31'd0, sched_done}, 32'd1);
        chk({pfx, "_end_valid"}, {31'd0, w_valid}, 32'd0);
        chk({pfx, "_end_ready"}, {31'd0, blk_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        logic rdy;
        logic stalled;
        logic [31:0] held;

        // Reset state, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_ready", {31'd0, blk_ready}, 32'd1);
        chk("rst_done", {31'd0, sched_done}, 32'd0);
        chk("rst_cnt", {24'd0, w_cnt}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_ready", {31'd0, blk_ready}, 32'd1);
        chk("idle_valid", {31'd0, w_valid}, 32'd0);

        // A: "abc" block, no backpressure
        blk_data = BLK_ABC;
        blk_valid = 1'b1;
        w_ready = 1'b1;
        step();
        blk_valid = 1'b0;
        run_stream(BLK_ABC, HAND_ABC, "A");
        step();
        chk("A_done_once", {31'd0, sched_done}, 32'd0);

        // B: same block with pseudo-random backpressure
        void'($urandom(32'h1234));
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (idx < 80 && cyc < 2000) begin
            chk($sformatf("B_valid%0d", idx), {31'd0, w_valid}, 32'd1);
            chk($sformatf("B_cnt%0d", idx), {24'd0, w_cnt}, idx);
            chk($sformatf("B_w%0d", idx), w_data, sha1_w(BLK_ABC, idx));
            if (stalled) chk($sformatf("B_stable%0d", idx), w_data, held);
            rdy = 1'($urandom_range(0, 1));
            w_ready = rdy;
            held = w_data;
            stalled = !rdy;
            step();
            cyc++;
            if (rdy) idx++;
        end
        chk("B_timeout", idx, 32'd80);
        chk("B_done_pulse", {31'd0, sched_done}, 32'd1);
        chk("B_end_valid", {31'd0, w_valid}, 32'd0);

        // C: blk_valid held high, all-ones block; new data offered mid-stream is ignored
        w_ready = 1'b1;
        blk_data = BLK_ONES;
        blk_valid = 1'b1;
        step();
        blk_data = BLK_ABC;
        run_stream(BLK_ONES, HAND_ONES, "C");
        step();
        chk("C_next_valid", {31'd0, w_valid}, 32'd1);
        chk("C_next_cnt", {24'd0, w_cnt}, 32'd0);
        chk("C_next_w0", w_data, 32'h61626380);
        chk("C_next_ready", {31'd0, blk_ready}, 32'd0);
        blk_valid = 1'b0;

        // D: abort at w_cnt = 40 while w_ready is high
        for (int t = 0; t < 40; t++) step();
        chk("D_cnt40", {24'd0, w_cnt}, 32'd40);
        chk("D_w40", w_data, sha1_w(BLK_ABC, 40));
        sched_abort = 1'b1;
        step();
        sched_abort = 1'b0;
        chk("D_valid", {31'd0, w_valid}, 32'd0);
        chk("D_cnt", {24'd0, w_cnt}, 32'd0);
        chk("D_ready", {31'd0, blk_ready}, 32'd1);
        chk("D_done", {31'd0, sched_done}, 32'd0);
        step();
        chk("D_done2", {31'd0, sched_done}, 32'd0);

        // Abort coincident with blk_valid in IDLE rejects the block
        blk_valid = 1'b1;
        sched_abort = 1'b1;
        step();
        blk_valid = 1'b0;
        sched_abort = 1'b0;
        chk("D_idle_abort_valid", {31'd0, w_valid}, 32'd0);
        chk("D_idle_abort_ready", {31'd0, blk_ready}, 32'd1);

        // E: asynchronous reset at w_cnt = 25, then a fresh "abc" block
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int t = 0; t < 25; t++) step();
        chk("E_cnt25", {24'd0, w_cnt}, 32'd25);
        rst_n = 1'b0;
        #1;
        chk("E_rst_valid", {31'd0, w_valid}, 32'd0);
        chk("E_rst_cnt", {24'd0, w_cnt}, 32'd0);
        chk("E_rst_ready", {31'd0, blk_ready}, 32'd1);
        chk("E_rst_done", {31'd0, sched_done}, 32'd0);
        #1 rst_n = 1'b1;
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        run_stream(BLK_ABC, HAND_ABC, "E");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/msg_schedule.md
MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 blk_valid  input  1  512-bit message block offered.
REQ-004 blk_data  input  512  padded block; word 0 = blk_data[511:480], word 15 = blk_data[31:0] (big-endian).
REQ-005 blk_ready  output  1  block accepted when blk_valid && blk_ready.
REQ-006 w_valid  output  1  w_data/w_cnt hold a valid schedule word.
REQ-007 w_ready  input  1  consumer (rounds loop) accepts word when w_valid && w_ready.
REQ-008 w_data  output  32  schedule word W[w_cnt].
REQ-009 w_cnt  output  8  index of current word, 0..79; matches the rounds_cnt encoding.
REQ-010 sched_abort  input  1  synchronous abort of current block.
REQ-011 sched_done  output  1  one-cycle pulse on transfer of W[79].

Function
REQ-012 States SHALL be IDLE and STREAM; blk_ready SHALL equal (state == IDLE).
REQ-013 IDLE + blk_valid SHALL load the 16 block words into a 16-entry circular buffer, clear w_cnt to 0, and enter STREAM; w_valid high the next cycle (1-cycle latency).
REQ-014 In STREAM, w_valid SHALL be 1; a transfer SHALL increment w_cnt by 1.
REQ-015 For w_cnt < 16, w_data SHALL be buf[w_cnt mod 16].
REQ-016 For w_cnt >= 16, w_data SHALL be rotl1(buf[(t+13)%16] ^ buf[(t+8)%16] ^ buf[(t+2)%16] ^ buf[t%16]), t = w_cnt, i.e. rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
REQ-017 On transfer with w_cnt >= 16, the computed word SHALL be written to buf[w_cnt mod 16]; no buffer write otherwise in STREAM.
REQ-018 w_data and w_cnt SHALL be functions of registered state only and SHALL stay stable while w_valid && !w_ready (backpressure, unlimited stall).
REQ-019 Transfer at w_cnt == 79 SHALL pulse sched_done for exactly that cycle's successor (registered, 1 cycle), drop w_valid, and return to IDLE; blk_ready = 1 the following cycle.
REQ-020 w_cnt SHALL never exceed 79; no wrap to 80.
REQ-021 blk_valid in STREAM SHALL be ignored (blk_ready = 0, no buffer change).
REQ-022 sched_abort SHALL take priority over transfer: next cycle IDLE, w_valid = 0, w_cnt = 0, no sched_done; buffer contents don't-care.
REQ-023 sched_abort in IDLE SHALL have no effect; an abort coincident with blk_valid in IDLE SHALL still reject the block (no load).
REQ-024 All arithmetic SHALL be 32-bit XOR/rotate; no carries.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, w_valid = 0, w_cnt = 0, sched_done = 0, blk_ready = 1, all buffer entries = 0.
REQ-026 Reset asserted mid-STREAM SHALL discard the block; first post-reset cycle behaves as fresh IDLE.

Verification
REQ-027 "abc" block (W0 = 32'h61626380, W1..W14 = 0, W15 = 32'h00000018), w_ready = 1 -> W[0]..W[15] as loaded, W[16] = 32'hC2C4C700, W[17] = 0, W[18] = 32'h00000030, W[19] = 32'h85898E01; 80 words on 80 consecutive cycles, sched_done once.
REQ-028 Same block, w_ready toggled pseudo-randomly -> identical word sequence vs. a reference SHA-1 schedule model, w_data stable during every stall.
REQ-029 blk_valid held high throughout -> second block accepted only in the cycle after sched_done; its W[0] appears next cycle.
REQ-030 sched_abort at w_cnt = 40 with w_ready = 1 -> no transfer of W[40], w_valid = 0 next cycle, no sched_done, blk_ready = 1.
REQ-031 rst_n pulsed low at w_cnt = 25 -> outputs at reset values asynchronously; new "abc" block then yields REQ-027 sequence exactly.
REQ-032 All-ones block (every Wi = 32'hFFFFFFFF) -> W[16] = 32'h00000000, W[19] = 32'hFFFFFFFF.
